// File: rtl/key_filter_pkg.sv
// Shared types and timing constants for the push-button debounce filter (key_filter).
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } key_state_t;

  localparam int unsigned KEY_CNT_MAX_20MS = 32'd999_999;
  localparam int unsigned KEY_LONG_MAX_1S  = 32'd49_999_999;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_filter_sync.sv
// Two-flop synchroniser for the raw key pin plus a history flop for edge detection.
module key_sync
  import key_filter_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic Clk50M,
  input  logic Rst,
  input  logic key_in,
  output logic nedge,
  output logic pedge,
  output logic s1
);

  logic s0;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      s0 <= RST_VAL;
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s0 <= key_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign nedge = s2 & ~s1;
  assign pedge = ~s2 & s1;

endmodule

// File: rtl/key_filter.sv
// Debounce filter with press/release event pulse; optional long-press pulse when
// KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = KEY_CNT_MAX_20MS,
  parameter int unsigned LONG_MAX = KEY_LONG_MAX_1S
) (
  input  logic Clk50M,
  input  logic Rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
`ifdef KEY_FILTER_LONG_PRESS_EN
  ,
  output logic key_long
`endif
);

  localparam int unsigned CNT_W = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic nedge;
  logic pedge;
  logic key_lvl;

  key_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .Clk50M(Clk50M),
    .Rst   (Rst),
    .key_in(key_in),
    .nedge (nedge),
    .pedge (pedge),
    .s1    (key_lvl)
  );

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             press_acc;
  logic             release_acc;

  // An opposite edge on the final window cycle aborts the event.
  assign press_acc   = (state == FILTER0) && !pedge && (cnt == CNT_LAST);
  assign release_acc = (state == FILTER1) && !nedge && (cnt == CNT_LAST);

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      key_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (nedge) begin
            state <= FILTER0;
            cnt   <= '0;
          end
        end
        FILTER0: begin
          if (pedge) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (press_acc) begin
            state     <= DOWN;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= key_lvl;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (pedge) begin
            state <= FILTER1;
            cnt   <= '0;
          end
        end
        FILTER1: begin
          if (nedge) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (release_acc) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b1;
            key_state <= key_lvl;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int unsigned LCNT_W = cnt_width(LONG_MAX);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_MAX);

  logic [LCNT_W-1:0] lcnt;
  logic              long_done;

  // lcnt holds through a release bounce, so one press yields at most one key_long.
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      lcnt      <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (press_acc || release_acc) begin
        lcnt      <= '0;
        long_done <= 1'b0;
      end else if (state == DOWN) begin
        if (lcnt != LCNT_LAST) begin
          lcnt <= lcnt + LCNT_W'(1);
        end else if (!long_done) begin
          key_long  <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter: directed scenarios plus random key waveforms
// compared against a sample-window reference model.
module tb_key_filter;

  localparam int CNT_MAX  = 9;
  localparam int LONG_MAX = 29;
  localparam int LAT      = CNT_MAX + 3;

  logic Clk50M;
  logic Rst;
  logic key_in;
  logic key_flag;
  logic key_state;
`ifdef KEY_FILTER_LONG_PRESS_EN
  logic key_long;
`endif

  key_filter #(
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .Clk50M   (Clk50M),
    .Rst      (Rst),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
`ifdef KEY_FILTER_LONG_PRESS_EN
    ,
    .key_long (key_long)
`endif
  );

  initial Clk50M = 1'b0;
  always #10 Clk50M = ~Clk50M;

  int checks   = 0;
  int failures = 0;

  int   cyc           = 0;
  int   n_flag        = 0;
  int   last_flag_cyc = -1;
  logic prev_flag     = 1'b0;
  int   n_long        = 0;
  int   last_long_cyc = -1;

  // Reference model: a transition away from the debounced level at sample N is
  // accepted if samples N..N+CNT_MAX+1 all stay away; the outputs follow two
  // edges after that deciding sample.
  bit   m_prev   = 1'b1;
  bit   m_lvl    = 1'b1;
  bit   m_active = 1'b0;
  int   m_run    = 0;
  bit   pf[2]    = '{1'b0, 1'b0};
  bit   pl[2]    = '{1'b1, 1'b1};
  logic exp_flag  = 1'b0;
  logic exp_state = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit x, input bit r);
    bit fl;
    if (r) begin
      m_prev    = 1'b1;
      m_lvl     = 1'b1;
      m_active  = 1'b0;
      m_run     = 0;
      pf        = '{1'b0, 1'b0};
      pl        = '{1'b1, 1'b1};
      exp_flag  = 1'b0;
      exp_state = 1'b1;
      return;
    end
    exp_flag  = pf[1];
    exp_state = pl[1];
    pf[1]     = pf[0];
    pl[1]     = pl[0];
    fl        = 1'b0;
    if (!m_active) begin
      if (m_prev == m_lvl && x != m_lvl) begin
        m_active = 1'b1;
        m_run    = 0;
      end
    end else if (x == m_lvl) begin
      m_active = 1'b0;
    end else begin
      m_run++;
      if (m_run == CNT_MAX + 1) begin
        m_lvl    = x;
        m_active = 1'b0;
        fl       = 1'b1;
      end
    end
    pf[0]  = fl;
    pl[0]  = m_lvl;
    m_prev = x;
  endtask

  task automatic tick(input logic k, input logic r);
    key_in = k;
    Rst    = r;
    @(posedge Clk50M);
    model_edge(k, r);
    @(negedge Clk50M);
    cyc++;
    check("key_flag", key_flag, exp_flag);
    check("key_state", key_state, exp_state);
    check("flag_back_to_back", key_flag & prev_flag, 0);
    prev_flag = key_flag;
    if (key_flag === 1'b1) begin
      n_flag++;
      last_flag_cyc = cyc;
    end
`ifdef KEY_FILTER_LONG_PRESS_EN
    if (key_long === 1'b1) begin
      n_long++;
      last_long_cyc = cyc;
    end
`endif
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  initial begin
    int c0;
    logic cur;
    key_in = 1'b1;
    Rst    = 1'b1;

    // Reset with pin released: outputs at reset values, no event afterwards.
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("reset_state", key_state, 1);
    check("reset_flag", key_flag, 0);
    n_flag = 0;
    run(1'b1, 8);
    check("no_event_after_reset", n_flag, 0);

    // Clean press: first low sample at edge c0, flag at c0+12.
    n_flag = 0;
    n_long = 0;
    c0 = cyc + 1;
    run(1'b0, 16);
    check("press_count", n_flag, 1);
    check("press_latency", last_flag_cyc - c0, LAT);
    check("press_level", key_state, 0);
`ifdef KEY_FILTER_LONG_PRESS_EN
    run(1'b0, 56);
    check("long_count", n_long, 1);
    check("long_latency", last_long_cyc - (c0 + LAT), LONG_MAX + 1);
`endif

    // Clean release.
    n_flag = 0;
    c0 = cyc + 1;
    run(1'b1, 15);
    check("release_count", n_flag, 1);
    check("release_latency", last_flag_cyc - c0, LAT);
    check("release_level", key_state, 1);
`ifdef KEY_FILTER_LONG_PRESS_EN
    check("long_single", n_long, 1);
`endif

    // Bounce: 5 low, 2 high, then held low.
    n_flag = 0;
    run(1'b0, 5);
    run(1'b1, 2);
    check("bounce_quiet", n_flag, 0);
    c0 = cyc + 1;
    run(1'b0, 15);
    check("bounce_count", n_flag, 1);
    check("bounce_latency", last_flag_cyc - c0, LAT);

    // Release glitch of 4 cycles from DOWN produces nothing.
    n_flag = 0;
    run(1'b1, 4);
    run(1'b0, 15);
    check("glitch_count", n_flag, 0);
    check("glitch_level", key_state, 0);
    run(1'b1, 15);

    // Edge priority: rising edge coincides with the terminal count.
    n_flag = 0;
    run(1'b0, CNT_MAX + 1);
    run(1'b1, 15);
    check("priority_count", n_flag, 0);
    check("priority_level", key_state, 1);

    // Reset at cycle 6 of FILTER0, pin held low through deassertion.
    n_flag = 0;
    run(1'b0, 8);
    tick(1'b0, 1'b1);
    check("midreset_flag", n_flag, 0);
    check("midreset_level", key_state, 1);
    c0 = cyc + 1;
    run(1'b0, 15);
    check("held_low_count", n_flag, 1);
    check("held_low_latency", last_flag_cyc - c0, LAT);
    run(1'b1, 15);

    // Random bounce/stable segments with occasional resets.
    cur = 1'b1;
    for (int s = 0; s < 400; s++) begin
      int len;
      cur = ~cur;
      len = ($urandom_range(1, 0) == 0) ? int'($urandom_range(10, 1))
                                        : int'($urandom_range(25, 11));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(199, 0) == 0) tick(cur, 1'b1);
        else tick(cur, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
